// File: rtl/pong_pkg.sv
// Shared Pong definitions.
//   SEL_CONTINUE / SEL_RESTART : Pause-menu selection encodings carried on `value`.
//   DEFAULT_DEBOUNCE_CYCLES    : debounce hold time, 10 ms at a 50 MHz clock.
package pong_pkg;

  localparam logic SEL_CONTINUE = 1'b0;
  localparam logic SEL_RESTART  = 1'b1;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce.sv
// Synchronizes one asynchronous contact and debounces it.
//   clock, reset_n : system clock, asynchronous active-low reset
//   raw            : asynchronous contact input, active-high
//   level          : debounced level (the `stable` register)
//   rise           : high for one cycle after `stable` goes 0 -> 1
//   agree          : synchronized input currently equals `stable`
// `stable` flips only after the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any return to `stable` restarts the count.
module debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic agree
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_a   <= raw;
      sync_b   <= sync_a;
      stable_q <= stable;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_q;
  assign agree = (sync_b == stable);

endmodule

// File: rtl/menu_input_ctrl.sv
// Joystick front end for the Pong main FSM.
//   clock, reset_n          : system clock, asynchronous active-low reset
//   btn_raw/up_raw/down_raw : asynchronous joystick contacts, active-high
//   enable_pause            : high while the Pause menu is shown
//   enter                   : one-cycle pulse per accepted button press
//   value                   : Pause-menu selection (SEL_CONTINUE / SEL_RESTART)
//   btn_level               : debounced button level
module menu_input_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic up_raw,
  input  logic down_raw,
  input  logic enable_pause,
  output logic enter,
  output logic value,
  output logic btn_level
);

  // Arming needs the button confirmed low for DEBOUNCE_CYCLES+2 consecutive
  // cycles. The extra 2 cycles cover the synchronizer, whose reset value of 0
  // would otherwise make a button held through reset look released.
  localparam int               ARM_W    = CNT_W + 2;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);

  logic             btn_rise;
  logic             btn_agree;
  logic             up_rise;
  logic             down_rise;
  logic             unused_up_level;
  logic             unused_up_agree;
  logic             unused_down_level;
  logic             unused_down_agree;

  logic             armed;
  logic [ARM_W-1:0] arm_cnt;
  logic             pause_q;
  logic             fire;
  logic             value_next;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (btn_raw),
    .level   (btn_level),
    .rise    (btn_rise),
    .agree   (btn_agree)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (up_raw),
    .level   (unused_up_level),
    .rise    (up_rise),
    .agree   (unused_up_agree)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (down_raw),
    .level   (unused_down_level),
    .rise    (down_rise),
    .agree   (unused_down_agree)
  );

  always_comb begin
    fire       = btn_rise & armed;
    value_next = value;
    if (!enable_pause || !pause_q) begin
      // Outside the menu, and on the cycle the menu opens, default to Continue.
      value_next = SEL_CONTINUE;
    end else if (btn_rise || enter) begin
      // Freeze the selection around the enter pulse so the main FSM sees a
      // value consistent with the press it is acting on.
      value_next = value;
    end else if (up_rise && !down_rise) begin
      value_next = SEL_CONTINUE;
    end else if (down_rise && !up_rise) begin
      value_next = SEL_RESTART;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
      pause_q <= 1'b0;
      enter   <= 1'b0;
      value   <= SEL_CONTINUE;
    end else begin
      pause_q <= enable_pause;
      enter   <= fire;
      value   <= value_next;
      if (!armed) begin
        if (btn_agree && !btn_level) begin
          if (arm_cnt == ARM_LAST) begin
            armed <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end else begin
          arm_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: doc/menu_input_ctrl.md
# menu_input_ctrl

Conditions the raw joystick signals into the clean `enter` and `value` inputs the Pong main FSM consumes. It synchronizes and debounces the joystick button and up/down contacts. It emits a single-cycle `enter` pulse per physical press and holds the Pause-menu selection (`value`: 0 = Continue, 1 = Restart) stable around that pulse. It sits between the board joystick pins and the main FSM, on the same `clock`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized input must stay at its new level before it is accepted (10 ms at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.
- `clock`  in  1  system clock; all flops on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  joystick push button, asynchronous, active-high.
- `up_raw`  in  1  joystick up contact, asynchronous, active-high.
- `down_raw`  in  1  joystick down contact, asynchronous, active-high.
- `enable_pause`  in  1  from main FSM, synchronous to `clock`; high while the Pause menu is shown.
- `enter`  out  1  registered; one-cycle pulse per accepted button press.
- `value`  out  1  registered Pause-menu selection: 0 = Continue, 1 = Restart.
- `btn_level`  out  1  debounced button level, for menu rendering and debug.

## Operation
- **Synchronizer:** each raw input passes through 2 flops before any other logic sees it.
- **Debounce:** one independent instance per input, with state `stable` and counter `cnt`.
  - If the synced input equals `stable`, `cnt` ← 0.
  - Otherwise `cnt` increments.
  - When `cnt` = `DEBOUNCE_CYCLES-1` and the input still differs, `stable` flips and `cnt` ← 0.
  - Any bounce back to `stable` restarts the count from 0.
- **Press edge:** `press` = `stable` rises (0→1) this cycle, from a registered previous `stable`.
- **Arming:**
  - `armed` is cleared by reset and set once the debounced button is seen low.
  - `enter` fires only when `press` occurs and `armed` = 1.
  - A button held through reset therefore produces no `enter` until it has been released and pressed again.
- **`enter`:** asserted high for exactly one cycle on each qualifying press. Releasing the button never produces a pulse.
- **Selection (`value`):**
  - On the rising edge of `enable_pause` (registered compare), `value` ← 0, so Continue is the default.
  - While `enable_pause` = 1:
    - debounced up press → `value` ← 0;
    - debounced down press → `value` ← 1;
    - value saturates and does not wrap.
  - While `enable_pause` = 0, `value` is held at 0.
  - Up and down presses in the same cycle: both are ignored.
  - Up or down press in the same cycle as a button press: the `enter` pulse is issued and the selection update is dropped. `value` does not change in the cycle `enter` is high or in the following cycle.
- **Reset values:** `enter` = 0, `value` = 0, `btn_level` = 0; all `stable`, `cnt`, `armed` and edge registers = 0.
- **Mid-operation reset:** all state is cleared immediately and no partial count survives.

## Timing
- Button latency: for a clean level change at `btn_raw`:
  - 2 cycles of synchronizer;
  - `DEBOUNCE_CYCLES` cycles to flip `stable`;
  - 1 cycle to register `enter`;
  - so `enter` is high in cycle D+3 after the change, counting the first sampling edge as cycle 1.
- Up/down latency: D+3 cycles to the `value` update.
- `btn_level` follows `stable`, which is D+2 cycles after a clean change.
- The main FSM samples `enter` and `value` on the same edge; `value` is guaranteed stable for the full cycle in which `enter` = 1.
- Minimum spacing between two `enter` pulses is 2·D cycles (press plus release debounce).

## Structure
- Shared package `pong_pkg`:
  - `SEL_CONTINUE` = 1'b0, `SEL_RESTART` = 1'b1;
  - default `DEBOUNCE_CYCLES`.
- Sub-module `debounce`:
  - 2-flop synchronizer, counter and `stable` register, with a `rise` output;
  - parameterized by `DEBOUNCE_CYCLES` and `CNT_W`;
  - instantiated 3 times.
- The top level holds the arming, enter and selection logic.

## Test plan
All scenarios use D = 4.
1. **Clean press:** `btn_raw` 0→1 and held for 20 cycles → `enter` high for exactly 1 cycle, 7 cycles after the change; `btn_level` = 1 after 6 cycles. Release → no pulse.
2. **Bounce:** `btn_raw` toggles 1,0,1,0 on alternate cycles, then holds 1 → no pulse during the bouncing; a single `enter` 7 cycles after the final rise.
3. **Selection:**
   - `enable_pause` 0→1 → `value` = 0.
   - Down press → `value` = 1 after 7 cycles.
   - Second down press → `value` stays 1.
   - Up press → `value` = 0.
   - Drop `enable_pause` → `value` = 0.
4. **Simultaneous events:**
   - `value` = 1, then down and button pressed in the same cycle → `enter` pulses with `value` = 1 and `value` stays 1.
   - Up and down together → `value` unchanged.
5. **Reset while held:**
   - Button held, `reset_n` pulsed low mid-count → all outputs 0 immediately.
   - Button still held after reset → no `enter`.
   - Release, then press again → one `enter`.
6. **Outside Pause:** with `enable_pause` = 0, up/down activity leaves `value` = 0, and button presses still produce `enter` pulses.
